// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a big-endian, byte-addressed data memory.
// Sub-word stores are read-modify-write; loads are lane-selected and extended.
module mem_access_unit #(
  parameter int unsigned READ_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        store,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_writeenable,
  output logic        mem_memread,
  input  logic [31:0] mem_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam int unsigned CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(READ_WAIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          store_q, store_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic          mwe_q, mwe_d;
  logic          mrd_q, mrd_d;

  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;
  logic [31:0]   merged;
  logic          bad;

  // Lane k of the memory word sits at bits [31-8k -: 8] (big-endian).
  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0: byte_sel = mem_data[31:24];
      2'd1: byte_sel = mem_data[23:16];
      2'd2: byte_sel = mem_data[15:8];
      2'd3: byte_sel = mem_data[7:0];
      default: byte_sel = 8'h00;
    endcase
    half_sel = lane_q[1] ? mem_data[15:0] : mem_data[31:16];

    load_ext = mem_data;
    if (size_q == 2'b00) begin
      load_ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (size_q == 2'b01) begin
      load_ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end

    merged = mem_data;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
        default: merged = mem_data;
      endcase
    end else if (lane_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    size_d   = size_q;
    uns_d    = uns_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    err_d    = 1'b0;
    bad      = (op[1:0] == 2'b11) ||
               (op[1:0] == 2'b01 && addr[0]) ||
               (op[1:0] == 2'b10 && addr[1:0] != 2'b00);

    case (state_q)
      S_IDLE: begin
        if (req) begin
          store_d = store;
          size_d  = op[1:0];
          uns_d   = op[2];
          lane_d  = addr[1:0];
          wdata_d = wdata;
          maddr_d = {addr[31:2], 2'b00};
          if (bad) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (store && op[1:0] == 2'b10) begin
            state_d  = S_WRITE;
            mwdata_d = wdata;
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          if (store_q) begin
            mwdata_d = merged;
            state_d  = S_WRITE;
          end else begin
            rdata_d = load_ext;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so every output is a flop.
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    mrd_d  = (state_d == S_RD_WAIT);
    mwe_d  = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      store_q  <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      lane_q   <= 2'b00;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
      mwe_q    <= 1'b0;
      mrd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      store_q  <= store_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      lane_q   <= lane_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwe_q    <= mwe_d;
      mrd_q    <= mrd_d;
    end
  end

  assign rdata           = rdata_q;
  assign done            = done_q;
  assign err             = err_q;
  assign busy            = busy_q;
  assign mem_address     = maddr_q;
  assign mem_writedata   = mwdata_q;
  assign mem_writeenable = mwe_q;
  assign mem_memread     = mrd_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan steps plus randomized accesses,
// predicted by a byte-array memory model; a separate memory answers the DUT.
module tb_mem_access_unit;
  localparam int R = 2;

  logic        clk = 1'b0;
  logic        rst, req, store;
  logic [2:0]  op;
  logic [31:0] addr, wdata, rdata, mem_address, mem_writedata, mem_data;
  logic        done, err, busy, mem_writeenable, mem_memread;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.READ_WAIT(R)) dut (
    .clk(clk), .rst(rst), .req(req), .store(store), .op(op), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_writeenable(mem_writeenable), .mem_memread(mem_memread),
    .mem_data(mem_data), .dbg_state(dbg_state)
  );

  // Environment memory seen by the DUT; exp_mem is the reference copy.
  logic [7:0] env_mem [256];
  logic [7:0] exp_mem [256];
  logic       load_mem = 1'b0;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= exp_mem[i];
    end else if (mem_writeenable) begin
      env_mem[{mem_address[7:2], 2'd0}] <= mem_writedata[31:24];
      env_mem[{mem_address[7:2], 2'd1}] <= mem_writedata[23:16];
      env_mem[{mem_address[7:2], 2'd2}] <= mem_writedata[15:8];
      env_mem[{mem_address[7:2], 2'd3}] <= mem_writedata[7:0];
    end
  end

  assign mem_data = {env_mem[{mem_address[7:2], 2'd0}], env_mem[{mem_address[7:2], 2'd1}],
                     env_mem[{mem_address[7:2], 2'd2}], env_mem[{mem_address[7:2], 2'd3}]};

  // Reference model state
  logic [31:0] exp_q [$];
  logic [31:0] exp_rdata = 32'h0;
  int          exp_lat, exp_rd_n, exp_we_cyc;
  logic        exp_err;
  logic [31:0] exp_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    int base;
    base = int'(a) & ~3;
    return {exp_mem[base], exp_mem[base + 1], exp_mem[base + 2], exp_mem[base + 3]};
  endfunction

  task automatic model(input logic st, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] wd);
    int          nbytes, b;
    logic [31:0] v;
    nbytes     = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
    b          = int'(a[7:0]);
    exp_err    = (o[1:0] == 2'b11) || ((a % nbytes) != 0);
    exp_rd_n   = 0;
    exp_we_cyc = 0;
    exp_wd     = 32'h0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!st) begin
      exp_lat  = R + 1;
      exp_rd_n = R;
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = (v << 8) | {24'h0, exp_mem[b + i]};
      if (nbytes < 4 && !o[2] && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
      exp_rdata = v;
    end else begin
      for (int i = 0; i < nbytes; i++) exp_mem[b + i] = wd[8*(nbytes-1-i) +: 8];
      exp_wd = word_at(a[7:0]);
      if (nbytes == 4) begin
        exp_lat = 2;  exp_we_cyc = 1;
      end else begin
        exp_lat = R + 2;  exp_rd_n = R;  exp_we_cyc = R + 1;
      end
    end
    exp_q.push_back(exp_rdata);
  endtask

  // Starts at a negedge; b2b means the previous access is sitting in DONE.
  task automatic access(input logic st, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep, input bit b2b);
    int          cyc, rd_n, rd_first, we_n, we_cyc;
    logic [31:0] wd_seen, rexp;
    bit          got;
    model(st, o, a, wd);
    store = st;  op = o;  addr = a;  wdata = wd;  req = 1'b1;
    if (b2b) @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'h0);
    cyc = 0;  rd_n = 0;  rd_first = 0;  we_n = 0;  we_cyc = 0;  wd_seen = 32'h0;  got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_memread) begin
        rd_n++;
        if (rd_first == 0) rd_first = cyc;
      end
      if (mem_writeenable) begin
        we_n++;
        we_cyc = cyc;
        wd_seen = mem_writedata;
      end
      if (done) got = 1;
    end
    check("done_seen", {31'h0, got}, 32'h1);
    check("done_cycle", cyc, exp_lat);
    check("err", {31'h0, err}, {31'h0, exp_err});
    check("busy_at_done", {31'h0, busy}, 32'h1);
    rexp = exp_q.pop_front();
    check("rdata", rdata, rexp);
    check("mem_address", mem_address, {a[31:2], 2'b00});
    check("rd_cycles", rd_n, exp_rd_n);
    if (exp_rd_n > 0) check("rd_first", rd_first, 1);
    check("we_count", we_n, (exp_we_cyc != 0) ? 1 : 0);
    if (exp_we_cyc != 0) begin
      check("we_cycle", we_cyc, exp_we_cyc);
      check("writedata", wd_seen, exp_wd);
    end
    if (!keep) begin
      req = 1'b0;
      @(negedge clk);
      check("done_pulse", {31'h0, done}, 32'h0);
      check("idle_after", {31'h0, busy}, 32'h0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_maddr"}, mem_address, 32'h0);
    check({tag, "_mwdata"}, mem_writedata, 32'h0);
    check({tag, "_ctl"}, {25'h0, done, err, busy, mem_writeenable, mem_memread, dbg_state}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          bb, kp;
    logic        st;
    logic [2:0]  o;
    int          hit_done, hit_we;
    rst = 1'b1;  req = 1'b0;  store = 1'b0;  op = 3'b0;  addr = 32'h0;  wdata = 32'h0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'($urandom_range(0, 255));
    exp_mem[16] = 8'h11;  exp_mem[17] = 8'h22;  exp_mem[18] = 8'h83;  exp_mem[19] = 8'h44;
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed plan steps
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, 0);
    check("plan_lw", rdata, 32'h11228344);
    access(1'b0, 3'b000, 32'h12, 32'h0, 0, 0);
    check("plan_lb", rdata, 32'hFFFFFF83);
    access(1'b0, 3'b100, 32'h12, 32'h0, 0, 0);
    check("plan_lbu", rdata, 32'h00000083);
    access(1'b0, 3'b001, 32'h12, 32'h0, 0, 0);
    check("plan_lh", rdata, 32'hFFFF8344);
    access(1'b0, 3'b101, 32'h10, 32'h0, 0, 0);
    check("plan_lhu", rdata, 32'h00001122);
    access(1'b1, 3'b000, 32'h11, 32'h000000AB, 0, 0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, 0);
    check("plan_sb_lw", rdata, 32'h11AB8344);
    access(1'b1, 3'b010, 32'h14, 32'hDEADBEEF, 0, 0);
    access(1'b1, 3'b001, 32'h16, 32'h00001234, 0, 0);
    access(1'b0, 3'b010, 32'h14, 32'h0, 0, 0);
    check("plan_sh_lw", rdata, 32'hDEAD1234);
    access(1'b1, 3'b001, 32'h11, 32'h0000FFFF, 0, 0);
    access(1'b0, 3'b010, 32'h12, 32'h0, 0, 0);
    access(1'b0, 3'b011, 32'h10, 32'h0, 0, 0);
    check("plan_err_rdata", rdata, 32'hDEAD1234);

    // Reset during RD_WAIT of a byte store: access dropped, nothing written
    store = 1'b1;  op = 3'b000;  addr = 32'h10;  wdata = 32'h55;  req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;  req = 1'b0;
    exp_rdata = 32'h0;
    hit_done = 0;  hit_we = 0;
    repeat (R + 3) begin
      @(negedge clk);
      if (done) hit_done++;
      if (mem_writeenable) hit_we++;
    end
    check("midrst_no_done", hit_done, 0);
    check("midrst_no_we", hit_we, 0);
    check("midrst_mem", {env_mem[16], env_mem[17], env_mem[18], env_mem[19]}, word_at(8'h10));

    // rst and req in the same cycle: the request is dropped
    store = 1'b0;  op = 3'b010;  addr = 32'h10;  req = 1'b1;  rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;  req = 1'b0;
    @(negedge clk);
    check("rstreq_busy", {31'h0, busy}, 32'h0);
    check("rstreq_rd", {31'h0, mem_memread}, 32'h0);

    // Back-to-back with req held through done
    access(1'b0, 3'b010, 32'h10, 32'h0, 1, 0);
    access(1'b0, 3'b000, 32'h13, 32'h0, 0, 1);

    // Randomized accesses
    bb = 0;
    for (int n = 0; n < 120; n++) begin
      st = 1'($urandom_range(0, 1));
      o  = 3'($urandom_range(0, 7));
      kp = (n != 119) && ($urandom_range(0, 3) == 0);
      access(st, o, $urandom(), $urandom(), kp, bb);
      bb = kp;
    end

    @(negedge clk);
    for (int w = 0; w < 64; w++)
      check("mem_word", {env_mem[4*w], env_mem[4*w+1], env_mem[4*w+2], env_mem[4*w+3]},
            word_at(8'(4 * w)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
